// File: rtl/fmul_retire.sv
// ----------------------------------------------------------------------------
// fmul_retire
//   Result/retire stage placed behind the combinational single-precision
//   multiplier. Each result, its exception flag vector and its tag are queued
//   in a small in-order FIFO and offered to the consumer over valid/ready.
//   IEEE exception flags are accumulated into the sticky fflags register when
//   an entry retires (pops), and retired operations are counted.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   TAG_W  width of the operation tag
//   CNT_W  width of the retired-operation counter
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   in_valid    multiplier result valid          in_ready   stage can accept
//   in_rslt     32-bit result                    in_flag    {NV,DZ,OF,UF,NX}
//   in_tag      operation tag
//   out_valid   head entry valid                 out_ready  consumer accepts
//   out_rslt    head result                      out_flag   head flags
//   out_tag     head tag
//   csr_we      software write of sticky flags   csr_wdata  value written
//   fflags      sticky accumulated flags
//   count       FIFO occupancy                   retire_cnt retired ops
//
// Optional feature (macro FMUL_TRAP_EN)
//   trap_mask   input: flags that raise a trap on retire
//   trap        output: one-cycle pulse after a trapping retire
//   trap_tag    output: tag of the last trapping retire
// ----------------------------------------------------------------------------
module fmul_retire #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_rslt,
  input  logic [4:0]             in_flag,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_rslt,
  output logic [4:0]             out_flag,
  output logic [TAG_W-1:0]       out_tag,
  input  logic                   csr_we,
  input  logic [4:0]             csr_wdata,
  output logic [4:0]             fflags,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       retire_cnt
`ifdef FMUL_TRAP_EN
  ,
  input  logic [4:0]             trap_mask,
  output logic                   trap,
  output logic [TAG_W-1:0]       trap_tag
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CW-1:0]    cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  typedef struct packed {
    logic [31:0]      rslt;
    logic [4:0]       flag;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  logic [4:0]       fflags_q, fflags_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic             push;
  logic             pop;

  // Full/empty come from the registered occupancy only, so in_ready never
  // depends combinationally on out_ready; a full FIFO refuses a push even
  // when a pop happens in the same cycle.
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head      = mem_q[rd_ptr_q];

  // Storage holds stale data when empty; gate so the outputs read zero.
  assign out_rslt  = out_valid ? head.rslt : '0;
  assign out_flag  = out_valid ? head.flag : '0;
  assign out_tag   = out_valid ? head.tag  : '0;

  assign fflags     = fflags_q;
  assign count      = count_q;
  assign retire_cnt = retire_cnt_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fflags_d     = fflags_q;
    retire_cnt_d = retire_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);   // DEPTH is a power of two: natural wrap
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    // A software write and a same-cycle retire both take effect.
    fflags_d = (csr_we ? csr_wdata : fflags_q) | (pop ? head.flag : 5'b0);

    if (pop) retire_cnt_d = retire_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fflags_q     <= '0;
      retire_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fflags_q     <= fflags_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; count gates validity, and unreset RAM maps to cheaper cells.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rslt: in_rslt, flag: in_flag, tag: in_tag};
  end

`ifdef FMUL_TRAP_EN
  logic             trap_q, trap_d;
  logic [TAG_W-1:0] trap_tag_q, trap_tag_d;

  // Trap decision uses the retiring entry's flags; fflags is unaffected.
  always_comb begin
    trap_d     = pop && ((head.flag & trap_mask) != 5'b0);
    trap_tag_d = trap_d ? head.tag : trap_tag_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_q     <= 1'b0;
      trap_tag_q <= '0;
    end else begin
      trap_q     <= trap_d;
      trap_tag_q <= trap_tag_d;
    end
  end

  assign trap     = trap_q;
  assign trap_tag = trap_tag_q;
`endif

endmodule

// File: tb/tb_fmul_retire.sv
// ----------------------------------------------------------------------------
// tb_fmul_retire
//   Directed scoreboard bench for fmul_retire (DEPTH=2, TAG_W=4, CNT_W=16).
//   Stimulus pushes each accepted entry's expected {rslt,flag,tag} into a
//   queue; a monitor on the falling edge pops and compares whenever the DUT
//   retires an entry, and checks that outputs read zero while empty.
//   Build with +define+FMUL_TRAP_EN to also exercise the trap outputs.
// ----------------------------------------------------------------------------
module tb_fmul_retire;

  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_rslt;
  logic [4:0]        in_flag;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_rslt;
  logic [4:0]        out_flag;
  logic [TAG_W-1:0]  out_tag;
  logic              csr_we;
  logic [4:0]        csr_wdata;
  logic [4:0]        fflags;
  logic [1:0]        count;
  logic [CNT_W-1:0]  retire_cnt;
`ifdef FMUL_TRAP_EN
  logic [4:0]        trap_mask;
  logic              trap;
  logic [TAG_W-1:0]  trap_tag;
`endif

  int checks   = 0;
  int failures = 0;

  logic [40:0] sb [$];   // {rslt, flag, tag}

  fmul_retire #(.DEPTH(2), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rslt    (in_rslt),
    .in_flag    (in_flag),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rslt   (out_rslt),
    .out_flag   (out_flag),
    .out_tag    (out_tag),
    .csr_we     (csr_we),
    .csr_wdata  (csr_wdata),
    .fflags     (fflags),
    .count      (count),
    .retire_cnt (retire_cnt)
`ifdef FMUL_TRAP_EN
    ,
    .trap_mask  (trap_mask),
    .trap       (trap),
    .trap_tag   (trap_tag)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one entry for the coming edge; expect_accept queues it.
  task automatic drive(input logic [31:0] r, input logic [4:0] f, input logic [TAG_W-1:0] t,
                       input bit expect_accept);
    in_valid = 1'b1;
    in_rslt  = r;
    in_flag  = f;
    in_tag   = t;
    if (expect_accept) sb.push_back({r, f, t});
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_rslt  = '0;
    in_flag  = '0;
    in_tag   = '0;
  endtask

  // Monitor: compare each retire against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_retire", {out_rslt, out_flag, out_tag}, 64'hdead);
          end else begin
            logic [40:0] exp_e;
            exp_e = sb.pop_front();
            check("retire_entry", {out_rslt, out_flag, out_tag}, exp_e);
          end
        end
      end else begin
        check("empty_outputs_zero", {out_rslt, out_flag, out_tag}, 64'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    out_ready = 1'b0;
    csr_we    = 1'b0;
    csr_wdata = '0;
`ifdef FMUL_TRAP_EN
    trap_mask = '0;
`endif
    idle_in();
    cyc();
    cyc();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_outputs", {out_rslt, out_flag, out_tag}, 0);
    check("rst_count", count, 0);
    check("rst_fflags", fflags, 0);
    check("rst_retire_cnt", retire_cnt, 0);
    reset = 1'b1;
    cyc();

    // Single push/retire: one-cycle latency, no bypass
    out_ready = 1'b1;
    drive(32'h3f800000, 5'b0, 4'd1, 1'b1);
    #1 check("no_bypass", out_valid, 0);
    cyc();
    idle_in();
    check("lat_out_valid", out_valid, 1);
    check("lat_out_rslt", out_rslt, 32'h3f800000);
    check("lat_out_tag", out_tag, 1);
    cyc();
    check("single_count", count, 0);
    check("single_retire_cnt", retire_cnt, 1);
    check("single_fflags", fflags, 0);

    // Fill with back-pressure; third push refused
    out_ready = 1'b0;
    drive(32'h40000000, 5'b0, 4'd1, 1'b1);
    cyc();
    drive(32'h40400000, 5'b0, 4'd2, 1'b1);
    cyc();
    check("full_count", count, 2);
    check("full_in_ready", in_ready, 0);
    drive(32'h40800000, 5'b0, 4'd3, 1'b0);
    cyc();
    idle_in();
    check("full_ignored_count", count, 2);
    check("hold_head_tag", out_tag, 1);
    out_ready = 1'b1;
    cyc();
    check("after_pop_in_ready", in_ready, 1);
    check("after_pop_count", count, 1);
    cyc();
    check("drain_count", count, 0);
    check("drain_retire_cnt", retire_cnt, 3);

    // Flag accumulation at retire
    drive(32'h7f800000, 5'b00101, 4'd4, 1'b1);
    cyc();
    check("flags_not_at_push", fflags, 0);
    drive(32'hffc00000, 5'b10000, 4'd5, 1'b1);
    cyc();
    idle_in();
    cyc();
    cyc();
    check("fflags_accum", fflags, 5'b10101);

    // CSR write racing a retire: both take effect
    out_ready = 1'b0;
    drive(32'h3f800001, 5'b00001, 4'd6, 1'b1);
    cyc();
    idle_in();
    csr_we    = 1'b1;
    csr_wdata = 5'b0;
    out_ready = 1'b1;
    cyc();
    csr_we = 1'b0;
    check("csr_write_plus_retire", fflags, 5'b00001);
    check("csr_retire_cnt", retire_cnt, 6);

    // Simultaneous push/pop at count=1: pointers wrap, order preserved
    out_ready = 1'b0;
    drive(32'h41000000, 5'b0, 4'd7, 1'b1);
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(32'h42000000 + 32'(i), 5'b0, 4'(8 + i), 1'b1);
      cyc();
      check("stream_count", count, 1);
    end
    idle_in();
    cyc();
    check("stream_drain_count", count, 0);
    check("stream_retire_cnt", retire_cnt, 15);
    check("stream_fflags", fflags, 5'b00001);

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    drive(32'h43000000, 5'b0, 4'd1, 1'b1);
    cyc();
    drive(32'h43800000, 5'b0, 4'd2, 1'b1);
    cyc();
    idle_in();
    check("pre_reset_count", count, 2);
    #2 reset = 1'b0;
    sb.delete();
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_count", count, 0);
    check("async_rst_retire_cnt", retire_cnt, 0);
    check("async_rst_fflags", fflags, 0);
    cyc();
    reset = 1'b1;
    out_ready = 1'b1;
    cyc();
    check("post_reset_out_valid", out_valid, 0);
    check("post_reset_retire_cnt", retire_cnt, 0);

`ifdef FMUL_TRAP_EN
    // Trap on NV retire, then a masked-out NX retire
    check("trap_rst", {trap, trap_tag}, 0);
    trap_mask = 5'b10000;
    drive(32'h7fc00000, 5'b10000, 4'd9, 1'b1);
    cyc();
    idle_in();
    check("trap_before_retire", trap, 0);
    cyc();
    check("trap_pulse", trap, 1);
    check("trap_tag", trap_tag, 9);
    cyc();
    check("trap_one_cycle", trap, 0);
    check("trap_tag_hold", trap_tag, 9);
    drive(32'h3f800001, 5'b00001, 4'd3, 1'b1);
    cyc();
    idle_in();
    cyc();
    check("no_trap_masked", trap, 0);
    check("no_trap_tag_hold", trap_tag, 9);
    check("trap_fflags", fflags, 5'b10001);
`endif

    cyc();
    check("sb_empty_at_end", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmul_retire.md
Name: fmul_retire

Overview:
- Result/retire stage directly downstream of the combinational single-precision multiplier.
- Captures each multiplier result and exception flag vector with its tag into a small in-order FIFO, presents it to the consumer over a valid/ready handshake, and accumulates sticky IEEE exception flags (fflags) on retire.
- Also counts retired operations and supports software read/write of the sticky flags.

Parameters:
- DEPTH, 2, FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the operation tag carried alongside each result.
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  multiplier result valid this cycle.
- in_ready  output  1  stage can accept a result.
- in_rslt  input  32  multiplier result.
- in_flag  input  5  exception flags: bit4 NV, bit3 DZ, bit2 OF, bit1 UF, bit0 NX.
- in_tag  input  TAG_W  operation tag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_rslt  output  32  head result.
- out_flag  output  5  head flags.
- out_tag  output  TAG_W  head tag.
- csr_we  input  1  software write of the sticky flags.
- csr_wdata  input  5  value written to the sticky flags.
- fflags  output  5  sticky accumulated flags.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- retire_cnt  output  CNT_W  number of retired operations.

Behaviour:
- Reset (reset low, asynchronous): FIFO empty, count=0, rd/wr pointers=0, fflags=0, retire_cnt=0.
  - Outputs during and after reset: out_valid=0, out_rslt=0, out_flag=0, out_tag=0, in_ready=1.
  - Reset mid-operation discards all entries without producing a retire.
- Push: in_valid & in_ready. Writes {in_rslt, in_flag, in_tag} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop (retire): out_valid & out_ready. rd_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH).
  - Depends only on registered count; there is no combinational path from out_ready to in_ready.
  - When full, no push is accepted even if a pop happens in the same cycle.
- out_valid = (count != 0). out_rslt/out_flag/out_tag are read from entry rd_ptr.
  - Contents are held stable while out_valid & ~out_ready.
  - Outputs are 0 when empty.
- Latency: a push into an empty FIFO appears on out_* the next cycle. There is no bypass.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, with both pointers advancing.
- Sticky flags, next value:
  - csr_we=1: fflags <= csr_wdata | (pop ? out_flag : 0). The write and a same-cycle retire both take effect.
  - csr_we=0: fflags <= fflags | (pop ? out_flag : 0).
  - Flags accumulate at retire, not at push.
- retire_cnt increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- in_rslt and in_flag are stored verbatim; no re-rounding or NaN rewriting.
- Pointer wrap-around: pointer width is $clog2(DEPTH); full/empty are determined from count, not by pointer compare.

Optional Feature:
- FMUL_TRAP_EN defined:
  - Adds input trap_mask[4:0], plus outputs trap (1 bit) and trap_tag (TAG_W).
  - On a pop where (out_flag & trap_mask) != 0, the next cycle has trap=1 for exactly one cycle and trap_tag = the retiring tag.
  - Otherwise trap=0, and trap_tag holds its last value.
  - Both trap and trap_tag reset to 0.
  - fflags accumulation is unaffected by trap_mask.
- FMUL_TRAP_EN undefined: the ports and logic are absent.

Test Plan:
- Reset, then push in_rslt=32'h3f800000, in_flag=0, in_tag=1 with out_ready=1 -> next cycle out_valid=1, out_rslt=3f800000, out_tag=1; following cycle count=0, retire_cnt=1, fflags=0.
- Hold out_ready=0 and push tags 1,2 -> count=2, in_ready=0, and a third push is ignored. Raise out_ready -> tags retire 1 then 2 in order, and in_ready=1 one cycle after the first pop.
- Push rslt=32'h7f800000, flag=5'b00101, then rslt=32'hffc00000, flag=5'b10000, and retire both -> fflags=5'b10101.
- With fflags=5'b10101, assert csr_we with csr_wdata=0 in the same cycle a flag=5'b00001 entry retires -> fflags=5'b00001.
- Simultaneous push and pop at count=1 for 8 cycles -> count stays 1, pointers wrap, and data order is preserved.
- Drop reset low while count=2 -> out_valid=0 and count=0 immediately. FMUL_TRAP_EN with trap_mask=5'b10000 and an NV retire -> trap=1 for one cycle with the correct trap_tag.
